// File: rtl/instr_issue_queue_if.sv
// Push/issue bundle for instr_issue_queue.
// Push side: instr/reg snapshots, valid, ready, flush. Issue side: idle, strobe, data, count, overflow.
interface instr_issue_queue_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PRIVATE_REG_WIDTH = 16,
  parameter int DEPTH             = 4
);
  logic [0:INSTRUCTION_WIDTH-1] instr_in;
  logic [PRIVATE_REG_WIDTH-1:0] reg_a_in;
  logic [PRIVATE_REG_WIDTH-1:0] reg_b_in;
  logic [PRIVATE_REG_WIDTH-1:0] reg_c_in;
  logic                         instr_valid_in;
  logic                         ready_out;
  logic                         flush_in;
  logic                         memory_idle_in;
  logic [0:INSTRUCTION_WIDTH-1] instr_out;
  logic [PRIVATE_REG_WIDTH-1:0] reg_a_out;
  logic [PRIVATE_REG_WIDTH-1:0] reg_b_out;
  logic [PRIVATE_REG_WIDTH-1:0] reg_c_out;
  logic                         instr_valid_out;
  logic [$clog2(DEPTH):0]       count_out;
  logic                         overflow_out;

  modport slave (
    input  instr_in, reg_a_in, reg_b_in, reg_c_in,
    input  instr_valid_in, flush_in, memory_idle_in,
    output ready_out, instr_out, reg_a_out, reg_b_out,
    output reg_c_out, instr_valid_out, count_out,
    output overflow_out
  );

  modport master (
    output instr_in, reg_a_in, reg_b_in, reg_c_in,
    output instr_valid_in, flush_in, memory_idle_in,
    input  ready_out, instr_out, reg_a_out, reg_b_out,
    input  reg_c_out, instr_valid_out, count_out,
    input  overflow_out
  );
endinterface

// File: rtl/instr_issue_queue.sv
// Buffered issue stage: FIFO of {instr, reg a/b/c}, one issue per idle window.
// Ports: clk_in, rst_in (sync, active-high), q (slave bundle: push side + issue side).
module instr_issue_queue #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PRIVATE_REG_WIDTH = 16,
  parameter int DEPTH             = 4,
  parameter int ISSUE_GAP         = 2
) (
  input logic                   clk_in,
  input logic                   rst_in,
  instr_issue_queue_if.slave    q
);
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int RW = PRIVATE_REG_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_ISSUE,
    S_GAP
  } state_t;

  logic [0:IW-1] mem_i [DEPTH];
  logic [RW-1:0] mem_a [DEPTH];
  logic [RW-1:0] mem_b [DEPTH];
  logic [RW-1:0] mem_c [DEPTH];

  state_t        st_q, st_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic [0:IW-1] ins_q, ins_d;
  logic [RW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic          full, push, pop;

  assign full = (cnt_q == CW'(DEPTH));

  always_comb begin
    st_d  = st_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    vld_d = vld_q;
    ovf_d = ovf_q;
    ins_d = ins_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (q.flush_in) begin
      // Flush drops any concurrent push silently; data regs hold.
      st_d  = S_WAIT;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else begin
      // Full refuses even when a pop happens this same edge.
      push = q.instr_valid_in && !full;
      if (q.instr_valid_in && full) ovf_d = 1'b1;
      unique case (st_q)
        S_WAIT: begin
          if (cnt_q != '0 && q.memory_idle_in) begin
            pop   = 1'b1;
            vld_d = 1'b1;
            ins_d = mem_i[rd_q];
            a_d   = mem_a[rd_q];
            b_d   = mem_b[rd_q];
            c_d   = mem_c[rd_q];
            st_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          vld_d = 1'b0;
          gap_d = GW'(ISSUE_GAP - 1);
          st_d  = S_GAP;
        end
        S_GAP: begin
          if (gap_q == '0) st_d = S_WAIT;
          else gap_d = gap_q - GW'(1);
        end
        default: st_d = S_WAIT;
      endcase
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q  <= S_WAIT;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      ins_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      st_q  <= st_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      ins_q <= ins_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      mem_i[wr_q] <= q.instr_in;
      mem_a[wr_q] <= q.reg_a_in;
      mem_b[wr_q] <= q.reg_b_in;
      mem_c[wr_q] <= q.reg_c_in;
    end
  end

  assign q.ready_out       = !full;
  assign q.count_out       = cnt_q;
  assign q.instr_valid_out = vld_q;
  assign q.overflow_out    = ovf_q;
  assign q.instr_out       = ins_q;
  assign q.reg_a_out       = a_q;
  assign q.reg_b_out       = b_q;
  assign q.reg_c_out       = c_q;
endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: queue-based reference model plus directed scenarios.
// Drives the master side of the bundle; compares every cycle on the falling edge.
module tb_instr_issue_queue;
  localparam int GAP = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_issue_queue_if #(
    .INSTRUCTION_WIDTH(32),
    .PRIVATE_REG_WIDTH(16),
    .DEPTH(DEP)
  ) bus ();

  instr_issue_queue #(
    .INSTRUCTION_WIDTH(32),
    .PRIVATE_REG_WIDTH(16),
    .DEPTH(DEP),
    .ISSUE_GAP(GAP)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .q(bus)
  );

  typedef struct packed {
    logic [31:0] i;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit armed = 0;

  ent_t mq[$];
  int blk = 0;
  bit ev = 0;
  bit eovf = 0;
  logic [31:0] ei = '0;
  logic [15:0] ea = '0, eb = '0, ec = '0;

  int strobes[$];
  logic [31:0] issued[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference: FIFO queue plus a cooldown counting cycles until idle is looked at again.
  always @(posedge clk) begin
    ent_t e;
    bit acc;
    if (rst) begin
      mq.delete();
      blk = 0; ev = 0; eovf = 0;
      ei = '0; ea = '0; eb = '0; ec = '0;
    end else if (bus.flush_in) begin
      mq.delete();
      blk = 0; ev = 0;
    end else begin
      acc = bus.instr_valid_in && (mq.size() != DEP);
      if (bus.instr_valid_in && mq.size() == DEP) eovf = 1;
      ev = 0;
      if (blk == 0 && mq.size() != 0 && bus.memory_idle_in) begin
        e = mq.pop_front();
        ev = 1;
        ei = e.i; ea = e.a; eb = e.b; ec = e.c;
        blk = 1 + GAP;
      end else if (blk > 0) begin
        blk--;
      end
      if (acc) begin
        e.i = bus.instr_in;
        e.a = bus.reg_a_in;
        e.b = bus.reg_b_in;
        e.c = bus.reg_c_in;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", 64'(bus.instr_valid_out), 64'(ev));
      chk("count", 64'(bus.count_out), 64'(mq.size()));
      chk("ready", 64'(bus.ready_out), 64'(mq.size() != DEP));
      chk("ovf", 64'(bus.overflow_out), 64'(eovf));
      chk("instr", 64'(bus.instr_out), 64'(ei));
      chk("reg_a", 64'(bus.reg_a_out), 64'(ea));
      chk("reg_b", 64'(bus.reg_b_out), 64'(eb));
      chk("reg_c", 64'(bus.reg_c_out), 64'(ec));
      if (bus.instr_valid_out) begin
        strobes.push_back(cyc);
        issued.push_back(bus.instr_out);
      end
    end
  end

  task automatic step(bit v, logic [31:0] ins, logic [15:0] r,
                      bit idle, bit fl = 0);
    bus.instr_valid_in = v;
    bus.instr_in       = ins;
    bus.reg_a_in       = r;
    bus.reg_b_in       = r + 16'd1;
    bus.reg_c_in       = r + 16'd2;
    bus.memory_idle_in = idle;
    bus.flush_in       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(int n, bit idle);
    repeat (n) step(0, '0, '0, idle);
  endtask

  task automatic clr();
    strobes.delete();
    issued.delete();
  endtask

  function automatic int sat(int k);
    return (k < strobes.size()) ? strobes[k] : -1;
  endfunction

  function automatic logic [31:0] iss(int k);
    return (k < issued.size()) ? issued[k] : 32'hFFFF_FFFF;
  endfunction

  int t0;

  initial begin
    bus.instr_valid_in = 0;
    bus.instr_in       = '0;
    bus.reg_a_in       = '0;
    bus.reg_b_in       = '0;
    bus.reg_c_in       = '0;
    bus.memory_idle_in = 0;
    bus.flush_in       = 0;
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;
    rst = 0;

    chk("rst_count", 64'(bus.count_out), 64'd0);
    chk("rst_ready", 64'(bus.ready_out), 64'd1);
    chk("rst_valid", 64'(bus.instr_valid_out), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_out), 64'd0);
    chk("rst_instr", 64'(bus.instr_out), 64'd0);

    clr();
    t0 = cyc;
    bus.reg_a_in = 16'd1;
    step(1, 32'h1234_5678, 16'd1, 1);
    wait_n(6, 1);
    chk("t2_nstrobe", 64'(strobes.size()), 64'd1);
    chk("t2_latency", 64'(sat(0) - t0), 64'd2);
    chk("t2_instr", 64'(bus.instr_out), 64'h1234_5678);
    chk("t2_a", 64'(bus.reg_a_out), 64'd1);
    chk("t2_b", 64'(bus.reg_b_out), 64'd2);
    chk("t2_c", 64'(bus.reg_c_out), 64'd3);
    chk("t2_count", 64'(bus.count_out), 64'd0);

    clr();
    for (int i = 0; i < 5; i++) step(1, 32'hA0 + i, 16'(i * 4), 0);
    chk("t3_count", 64'(bus.count_out), 64'd4);
    chk("t3_ready", 64'(bus.ready_out), 64'd0);
    chk("t3_ovf", 64'(bus.overflow_out), 64'd1);
    wait_n(20, 1);
    chk("t3_nstrobe", 64'(strobes.size()), 64'd4);
    for (int i = 1; i < 4; i++)
      chk("t3_spacing", 64'(sat(i) - sat(i - 1)), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", 64'(iss(i)), 64'(32'hA0 + i));
    chk("t3_last", 64'(bus.instr_out), 64'hA3);
    chk("t3_last_c", 64'(bus.reg_c_out), 64'd14);

    clr();
    t0 = cyc;
    step(1, 32'hB0, 16'd20, 1);
    step(1, 32'hB1, 16'd30, 1);
    wait_n(10, 0);
    wait_n(6, 1);
    chk("t4_nstrobe", 64'(strobes.size()), 64'd2);
    chk("t4_first", 64'(sat(0) - t0), 64'd2);
    chk("t4_second", 64'(sat(1) - t0), 64'd13);

    clr();
    t0 = cyc;
    step(1, 32'hC0, 16'd40, 0);
    step(1, 32'hC1, 16'd50, 1);
    chk("t5_count", 64'(bus.count_out), 64'd1);
    wait_n(8, 1);
    chk("t5_nstrobe", 64'(strobes.size()), 64'd2);
    chk("t5_first", 64'(sat(0) - t0), 64'd2);
    chk("t5_second", 64'(sat(1) - t0), 64'd6);
    chk("t5_order", 64'(iss(1)), 64'hC1);

    clr();
    for (int i = 0; i < 4; i++) step(1, 32'hD0 + i, 16'd60, 1);
    step(1, 32'hD4, 16'd70, 1, 1);
    chk("t6_count", 64'(bus.count_out), 64'd0);
    chk("t6_ovf", 64'(bus.overflow_out), 64'd1);
    wait_n(8, 1);
    chk("t6_nstrobe", 64'(strobes.size()), 64'd1);
    chk("t6_held", 64'(bus.instr_out), 64'hD0);
    clr();
    t0 = cyc;
    step(1, 32'hD5, 16'd80, 1);
    wait_n(5, 1);
    chk("t6_relat", 64'(sat(0) - t0), 64'd2);
    chk("t6_reinstr", 64'(bus.instr_out), 64'hD5);

    clr();
    step(1, 32'hE0, 16'd90, 1);
    rst = 1;
    step(0, '0, '0, 1);
    rst = 0;
    chk("t7_ovf", 64'(bus.overflow_out), 64'd0);
    chk("t7_count", 64'(bus.count_out), 64'd0);
    chk("t7_instr", 64'(bus.instr_out), 64'd0);
    wait_n(3, 1);
    chk("t7_nstrobe", 64'(strobes.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
